// File: rtl/pp_buf_ctrl_if.sv
// Valid/ready stream bundle for the ping-pong buffer: capture side in, consumer side out.
interface pp_buf_ctrl_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pp_buf_ctrl.sv
// Ping-pong controller: fills one external SDP RAM bank from the input stream
// while the other bank drains to the output stream.
module pp_buf_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  pp_buf_ctrl_if.slave      bus,
  output logic              o_ram_a_wea,
  output logic [ADDR_W-1:0] o_ram_a_addra,
  output logic [DATA_W-1:0] o_ram_a_dina,
  output logic [ADDR_W-1:0] o_ram_a_addrb,
  input  logic [DATA_W-1:0] i_ram_a_doutb,
  output logic              o_ram_b_wea,
  output logic [ADDR_W-1:0] o_ram_b_addra,
  output logic [DATA_W-1:0] o_ram_b_dina,
  output logic [ADDR_W-1:0] o_ram_b_addrb,
  input  logic [DATA_W-1:0] i_ram_b_doutb,
  output logic [1:0]        o_bank_full
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LEN_ONE = 1;

  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rstate_t;

  rstate_t           r_state;
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_len [2];
  logic [1:0]        r_bank_full;

  logic              w_in_ready;
  logic              w_acc;
  logic              w_wr_done;
  logic              w_stream;
  logic              w_last;
  logic              w_fire;
  logic              w_last_fire;
  logic [ADDR_W:0]   w_len_m1;
  logic [ADDR_W-1:0] w_rd_addrb;
  logic [1:0]        w_bf_nxt;

  assign w_in_ready  = ~r_bank_full[r_wr_sel];
  assign w_acc       = bus.in_valid & w_in_ready;
  assign w_wr_done   = w_acc & (bus.in_last | (r_wr_addr == ADDR_W'(DEPTH - 1)));

  assign w_stream    = (r_state == R_STREAM);
  assign w_len_m1    = r_len[r_rd_sel] - LEN_ONE;
  assign w_last      = w_stream & ({1'b0, r_rd_addr} == w_len_m1);
  assign w_fire      = w_stream & bus.out_ready;
  assign w_last_fire = w_fire & w_last;
  // Look one word ahead on a fire so back-to-back beats need no bubble;
  // otherwise hold the address so stalled data stays put.
  assign w_rd_addrb  = w_fire ? r_rd_addr + 1'b1 : r_rd_addr;

  // Fill and drain always touch different banks, so both updates can land.
  always_comb begin
    w_bf_nxt = r_bank_full;
    if (w_wr_done)   w_bf_nxt[r_wr_sel] = 1'b1;
    if (w_last_fire) w_bf_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= R_IDLE;
      r_wr_sel    <= 1'b0;
      r_rd_sel    <= 1'b0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_len[0]    <= '0;
      r_len[1]    <= '0;
      r_bank_full <= '0;
    end else begin
      r_bank_full <= w_bf_nxt;
      if (w_wr_done) begin
        r_len[r_wr_sel] <= {1'b0, r_wr_addr} + LEN_ONE;
        r_wr_sel        <= ~r_wr_sel;
        r_wr_addr       <= '0;
      end else if (w_acc) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      case (r_state)
        R_IDLE:   if (r_bank_full[r_rd_sel]) r_state <= R_PRIME;
        R_PRIME:  r_state <= R_STREAM;
        R_STREAM: begin
          if (w_last_fire) begin
            r_rd_sel  <= ~r_rd_sel;
            r_rd_addr <= '0;
            r_state   <= R_IDLE;
          end else if (w_fire) begin
            r_rd_addr <= r_rd_addr + 1'b1;
          end
        end
        default:  r_state <= R_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_stream;
  assign bus.out_last  = w_last;
  assign bus.out_data  = r_rd_sel ? i_ram_b_doutb : i_ram_a_doutb;

  assign o_ram_a_wea   = w_acc & ~r_wr_sel;
  assign o_ram_b_wea   = w_acc &  r_wr_sel;
  assign o_ram_a_addra = r_wr_addr;
  assign o_ram_b_addra = r_wr_addr;
  assign o_ram_a_dina  = bus.in_data;
  assign o_ram_b_dina  = bus.in_data;
  assign o_ram_a_addrb = r_rd_sel ? '0 : w_rd_addrb;
  assign o_ram_b_addrb = r_rd_sel ? w_rd_addrb : '0;
  assign o_bank_full   = r_bank_full;
endmodule
